// File: rtl/adc_pkg.sv
// Shared definitions for the SAR ADC sequencing controller: FSM encoding and
// default phase lengths.
package adc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SAMP   = 3'd2,
    ST_COMP   = 3'd3,
    ST_UPDATE = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int NBITS_DEF    = 16;
  localparam int T_SAMP_DEF   = 4;
  localparam int T_COMP_DEF   = 2;
  localparam int T_UPDATE_DEF = 1;
  localparam int TIMER_W      = 8;

endpackage

// File: rtl/adc_phase_timer.sv
// Loadable down-counter; tc is high on the last cycle of a phase
// (count has reached zero).
module adc_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/adc_seqctrl.sv
// SAR ADC sequencer: drives init/samp/comp/update phases, assembles serial
// comparator decisions MSB first and hands the word out through a holding register.
module adc_seqctrl
  import adc_pkg::*;
#(
  parameter int NBITS    = NBITS_DEF,
  parameter int T_SAMP   = T_SAMP_DEF,
  parameter int T_COMP   = T_COMP_DEF,
  parameter int T_UPDATE = T_UPDATE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             seq_init,
  output logic             seq_samp,
  output logic             seq_comp,
  output logic             seq_update,
  input  logic             comp_out,
  output logic [NBITS-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [TIMER_W-1:0] LD_SAMP = TIMER_W'(T_SAMP - 1);
  localparam logic [TIMER_W-1:0] LD_COMP = TIMER_W'(T_COMP - 1);
  localparam logic [TIMER_W-1:0] LD_UPD  = TIMER_W'(T_UPDATE - 1);

  // Result handshake: a word transfers on a rising edge where
  // result_valid && result_ready; result is held stable while result_valid.
  state_t             state, next_state;
  logic               tmr_load, tmr_tc;
  logic [TIMER_W-1:0] tmr_val;
  logic [IW-1:0]      idx;
  logic [NBITS-1:0]   sar;

  adc_phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      ST_IDLE: if (start) begin
        next_state = ST_INIT;
        tmr_load   = 1'b1;
      end
      ST_INIT: begin
        next_state = ST_SAMP;
        tmr_load   = 1'b1;
        tmr_val    = LD_SAMP;
      end
      ST_SAMP: if (tmr_tc) begin
        next_state = ST_COMP;
        tmr_load   = 1'b1;
        tmr_val    = LD_COMP;
      end
      // The final decision goes straight to DONE; no update follows it.
      ST_COMP: if (tmr_tc) begin
        tmr_load = 1'b1;
        if (idx == '0) begin
          next_state = ST_DONE;
        end else begin
          next_state = ST_UPDATE;
          tmr_val    = LD_UPD;
        end
      end
      ST_UPDATE: if (tmr_tc) begin
        next_state = ST_COMP;
        tmr_load   = 1'b1;
        tmr_val    = LD_COMP;
      end
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Phase outputs are registered from next_state so they align with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_init     <= 1'b0;
      seq_samp     <= 1'b0;
      seq_comp     <= 1'b0;
      seq_update   <= 1'b0;
      busy         <= 1'b0;
      idx          <= '0;
      sar          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      seq_init   <= (next_state == ST_INIT);
      seq_samp   <= (next_state == ST_SAMP);
      seq_comp   <= (next_state == ST_COMP);
      seq_update <= (next_state == ST_UPDATE);
      busy       <= (next_state != ST_IDLE);
      overrun    <= 1'b0;

      if (state == ST_INIT) begin
        idx <= IW'(NBITS - 1);
        sar <= '0;
      end
      if (state == ST_COMP && tmr_tc) sar[idx] <= comp_out;
      if (state == ST_UPDATE && tmr_tc) idx <= idx - IW'(1);

      if (state == ST_DONE) begin
        if (!result_valid || result_ready) begin
          result       <= sar;
          result_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (result_valid && result_ready) begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_seqctrl.sv
// Bench for adc_seqctrl: a default-parameter instance plus a small
// (NBITS=4) instance, fed serial comparator words from a reference pattern.
module tb_adc_seqctrl;

  localparam int NB = 16, TS = 4, TC = 2, TU = 1;
  localparam int NB_S = 4, TS_S = 2, TC_S = 3, TU_S = 2;
  localparam int L_CONV   = 1 + TS + NB * TC + (NB - 1) * TU;
  localparam int L_CONV_S = 1 + TS_S + NB_S * TC_S + (NB_S - 1) * TU_S;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start = 1'b0, busy, seq_init, seq_samp, seq_comp, seq_update;
  logic          comp_out = 1'b0, result_valid, result_ready = 1'b0, overrun;
  logic [NB-1:0] result;
  logic            start_s = 1'b0, busy_s, seq_init_s, seq_samp_s, seq_comp_s, seq_update_s;
  logic            comp_out_s = 1'b0, result_valid_s, result_ready_s = 1'b0, overrun_s;
  logic [NB_S-1:0] result_s;

  adc_seqctrl #(.NBITS(NB), .T_SAMP(TS), .T_COMP(TC), .T_UPDATE(TU)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .seq_init(seq_init), .seq_samp(seq_samp), .seq_comp(seq_comp), .seq_update(seq_update),
    .comp_out(comp_out), .result(result), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun)
  );

  adc_seqctrl #(.NBITS(NB_S), .T_SAMP(TS_S), .T_COMP(TC_S), .T_UPDATE(TU_S)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .busy(busy_s),
    .seq_init(seq_init_s), .seq_samp(seq_samp_s), .seq_comp(seq_comp_s), .seq_update(seq_update_s),
    .comp_out(comp_out_s), .result(result_s), .result_valid(result_valid_s),
    .result_ready(result_ready_s), .overrun(overrun_s)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the k-th comparator pulse of a conversion returns bit
  // NBITS-1-k of the word chosen for it; a completed conversion yields that word.
  logic [NB-1:0]   stim_q[$], exp_q[$], got_q[$], cur_word;
  logic [NB_S-1:0] stim_s_q[$], exp_s_q[$], got_s_q[$], cur_word_s;
  int comp_k = 0, comp_k_s = 0;
  logic pi_n = 1'b0, pc_n = 1'b0, pi_ns = 1'b0, pc_ns = 1'b0;

  always @(negedge clk) begin
    if (seq_init && !pi_n) begin
      cur_word = (stim_q.size() > 0) ? stim_q.pop_front() : NB'($urandom);
      exp_q.push_back(cur_word);
      comp_k = 0;
    end
    if (seq_comp && !pc_n) begin
      comp_out = (comp_k < NB) ? cur_word[NB-1-comp_k] : 1'b0;
      comp_k++;
    end
    pi_n = seq_init;
    pc_n = seq_comp;
    if (seq_init_s && !pi_ns) begin
      cur_word_s = (stim_s_q.size() > 0) ? stim_s_q.pop_front() : NB_S'($urandom);
      exp_s_q.push_back(cur_word_s);
      comp_k_s = 0;
    end
    if (seq_comp_s && !pc_ns) begin
      comp_out_s = (comp_k_s < NB_S) ? cur_word_s[NB_S-1-comp_k_s] : 1'b0;
      comp_k_s++;
    end
    pi_ns = seq_init_s;
    pc_ns = seq_comp_s;
  end

  // Phase monitors: index 0..3 = init, samp, comp, update.
  logic [3:0] ph, ph_s;
  assign ph   = {seq_init, seq_samp, seq_comp, seq_update};
  assign ph_s = {seq_init_s, seq_samp_s, seq_comp_s, seq_update_s};
  int exp_w[4]   = '{1, TS, TC, TU};
  int exp_w_s[4] = '{1, TS_S, TC_S, TU_S};
  int cnt[4], run[4], cnt_s[4], run_s[4];
  int wid_err, excl, ovr_cnt, vrun, vmax, cyc;
  int wid_err_s, excl_s, ovr_cnt_s;
  int init_t_q[$];

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (ph[3-i]) begin
        if (run[i] == 0) cnt[i]++;
        run[i]++;
        if (i == 0 && run[i] == 1) init_t_q.push_back(cyc);
      end else if (run[i] != 0) begin
        if (run[i] != exp_w[i]) wid_err++;
        run[i] = 0;
      end
      if (ph_s[3-i]) begin
        if (run_s[i] == 0) cnt_s[i]++;
        run_s[i]++;
      end else if (run_s[i] != 0) begin
        if (run_s[i] != exp_w_s[i]) wid_err_s++;
        run_s[i] = 0;
      end
    end
    if ($countones(ph) > 1) excl++;
    if ($countones(ph_s) > 1) excl_s++;
    if (overrun) ovr_cnt++;
    if (overrun_s) ovr_cnt_s++;
    if (result_valid && result_ready) got_q.push_back(result);
    if (result_valid_s && result_ready_s) got_s_q.push_back(result_s);
    if (result_valid) begin
      vrun++;
      if (vrun > vmax) vmax = vrun;
    end else begin
      vrun = 0;
    end
  end

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 0; run[i] = 0; cnt_s[i] = 0; run_s[i] = 0;
    end
    wid_err = 0; excl = 0; ovr_cnt = 0; vrun = 0; vmax = 0;
    wid_err_s = 0; excl_s = 0; ovr_cnt_s = 0;
    init_t_q.delete(); exp_q.delete(); got_q.delete();
    exp_s_q.delete(); got_s_q.delete();
  endtask

  // Leaves the bench at the negedge following the edge that samples start.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!result_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    @(negedge clk) result_ready = 1'b1;
    @(negedge clk) result_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ph, busy, result_valid, overrun} !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected 0", {ph, busy, result_valid, overrun});
    end
    checks++;
    if (result !== '0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", result);
    end
    checks++;
    if ({ph_s, busy_s, result_valid_s, overrun_s, result_s} !== '0) begin
      errors++; $display("FAIL reset_small: got %b expected 0", {ph_s, busy_s, result_valid_s, overrun_s, result_s});
    end
    rst = 1'b0;
    clear_mon();
  endtask

  task automatic test_single();
    int n;
    logic [NB-1:0] e;
    clear_mon();
    stim_q.push_back(16'hA5C3);
    pulse_start();
    wait_valid(300, n);
    checks++;
    if (n !== L_CONV + 1) begin
      errors++; $display("FAIL single_latency: got %0d expected %0d", n, L_CONV + 1);
    end
    checks++;
    if (result !== 16'hA5C3) begin
      errors++; $display("FAIL single_result: got %h expected a5c3", result);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL single_busy_low: got %b expected 0", busy);
    end
    checks++;
    if ({cnt[0], cnt[1], cnt[2], cnt[3]} !== {32'd1, 32'd1, 32'(NB), 32'(NB - 1)}) begin
      errors++; $display("FAIL single_pulse_counts: got %0d/%0d/%0d/%0d expected 1/1/%0d/%0d",
                         cnt[0], cnt[1], cnt[2], cnt[3], NB, NB - 1);
    end
    checks++;
    if (wid_err !== 0 || excl !== 0) begin
      errors++; $display("FAIL single_phase_shape: got wid_err=%0d excl=%0d expected 0/0", wid_err, excl);
    end
    drain();
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== e || result_valid !== 1'b0) begin
      errors++; $display("FAIL single_handshake: got n=%0d word=%h valid=%b expected 1 %h 0",
                         got_q.size(), (got_q.size() > 0) ? got_q[0] : 'x, result_valid, e);
    end
  endtask

  task automatic test_overrun();
    int n;
    clear_mon();
    result_ready = 1'b0;
    stim_q.push_back(16'h1234);
    stim_q.push_back(16'hFFFF);
    pulse_start();
    wait_valid(300, n);
    pulse_start();
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_pulse_at_end: got %b expected 1", overrun);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (result !== 16'h1234 || result_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_keeps_old: got %h valid=%b expected 1234 valid=1", result, result_valid);
    end
    checks++;
    if (ovr_cnt !== 1) begin
      errors++; $display("FAIL overrun_count: got %0d expected 1", ovr_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n, k;
    logic pc;
    clear_mon();
    stim_q.push_back(16'h0F0F);
    stim_q.push_back(16'h0F0F);
    pulse_start();
    k = 0; n = 0; pc = 1'b0;
    while (k < 5 && n < 300) begin
      @(negedge clk);
      n++;
      if (seq_comp && !pc) k++;
      pc = seq_comp;
    end
    checks++;
    if (k !== 5) begin
      errors++; $display("FAIL resetmid_reach_comp5: got %0d comp phases expected 5", k);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ph, busy, result_valid} !== 6'b0) begin
      errors++; $display("FAIL resetmid_async_clear: got %b expected 0", {ph, busy, result_valid});
    end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    clear_mon();
    pulse_start();
    wait_valid(300, n);
    checks++;
    if (result !== 16'h0F0F || result_valid !== 1'b1) begin
      errors++; $display("FAIL resetmid_next_result: got %h valid=%b expected 0f0f valid=1", result, result_valid);
    end
    drain();
  endtask

  task automatic test_ignored_start();
    int n;
    logic [NB-1:0] w;
    clear_mon();
    w = NB'($urandom);
    stim_q.push_back(w);
    pulse_start();
    n = 0;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
      start = (seq_samp || seq_comp) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    checks++;
    if (n !== L_CONV + 1 || result !== w) begin
      errors++; $display("FAIL ignored_result: got lat=%0d word=%h expected %0d %h", n, result, L_CONV + 1, w);
    end
    drain();
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL ignored_no_second_conv: got busy=%b expected 0", busy);
    end
    checks++;
    if ({cnt[0], cnt[1], cnt[2], cnt[3]} !== {32'd1, 32'd1, 32'(NB), 32'(NB - 1)}) begin
      errors++; $display("FAIL ignored_pulse_counts: got %0d/%0d/%0d/%0d expected 1/1/%0d/%0d",
                         cnt[0], cnt[1], cnt[2], cnt[3], NB, NB - 1);
    end
  endtask

  task automatic test_back_to_back();
    int n, bad;
    clear_mon();
    for (int i = 0; i < 3; i++) stim_q.push_back(NB'($urandom));
    @(negedge clk);
    result_ready = 1'b1;
    start = 1'b1;
    n = 0;
    while (got_q.size() < 3 && n < 400) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    result_ready = 1'b0;
    checks++;
    if (got_q.size() < 3 || got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d results expected %0d (>=3)", got_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; bad++;
        $display("FAIL b2b_word%0d: got %h expected %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 1; i < init_t_q.size(); i++) begin
      checks++;
      if (init_t_q[i] - init_t_q[i-1] !== L_CONV + 2) begin
        errors++; $display("FAIL b2b_period%0d: got %0d expected %0d", i, init_t_q[i] - init_t_q[i-1], L_CONV + 2);
      end
    end
    checks++;
    if (ovr_cnt !== 0 || vmax !== 1) begin
      errors++; $display("FAIL b2b_valid_shape: got overruns=%0d max_valid_run=%0d expected 0 1", ovr_cnt, vmax);
    end
  endtask

  task automatic test_small_params();
    int n;
    clear_mon();
    result_ready_s = 1'b1;
    for (int c = 0; c < 2; c++) begin
      stim_s_q.push_back(NB_S'($urandom));
      @(negedge clk) start_s = 1'b1;
      @(negedge clk) start_s = 1'b0;
      n = 0;
      while (!result_valid_s && n < 100) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (n !== L_CONV_S + 1) begin
        errors++; $display("FAIL small_latency%0d: got %0d expected %0d", c, n, L_CONV_S + 1);
      end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    result_ready_s = 1'b0;
    checks++;
    if ({cnt_s[0], cnt_s[1], cnt_s[2], cnt_s[3]} !== {32'd2, 32'd2, 32'(2 * NB_S), 32'(2 * (NB_S - 1))}) begin
      errors++; $display("FAIL small_pulse_counts: got %0d/%0d/%0d/%0d expected 2/2/%0d/%0d",
                         cnt_s[0], cnt_s[1], cnt_s[2], cnt_s[3], 2 * NB_S, 2 * (NB_S - 1));
    end
    checks++;
    if (wid_err_s !== 0 || excl_s !== 0 || ovr_cnt_s !== 0) begin
      errors++; $display("FAIL small_phase_shape: got wid_err=%0d excl=%0d ovr=%0d expected 0/0/0",
                         wid_err_s, excl_s, ovr_cnt_s);
    end
    checks++;
    if (got_s_q.size() !== 2 || exp_s_q.size() !== 2 || got_s_q[0] !== exp_s_q[0] || got_s_q[1] !== exp_s_q[1]) begin
      errors++; $display("FAIL small_results: got n=%0d expected 2 matching words", got_s_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_reset_mid();
    test_ignored_start();
    test_back_to_back();
    test_small_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
